// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module sync_fifo_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AF_CNT   = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE_CNT   = AE_LEVEL[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   count_q;
  logic             wr_ok;
  logic             rd_ok;

  // Handshake: winc/rinc are requests; a request is accepted only if wfull/rempty
  // (decoded from the registered count) is low before the edge. A rejected request
  // only sets the matching sticky error flag.
  assign wfull         = (count_q == FULL_CNT);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AF_CNT);
  assign ralmost_empty = (count_q <= AE_CNT);
  assign count         = count_q;

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wptr[ASIZE-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[rptr[ASIZE-1:0]];
`else
  always_ff @(posedge clk) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_ok) rdata <= mem[rptr[ASIZE-1:0]];
  end
`endif

endmodule
